// File: rtl/fetch_buffer_stage_pkg.sv
// Shared fetch-path definitions: architectural widths, the NOP encoding and
// the {pc, instr} entry carried through the fetch queue.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_stage_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; flush wins over push/pop and
// empties the queue by snapping head onto tail.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 96,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) mem[tail] <= din;
    end

    always_comb head_data = mem[head];

endmodule

// File: rtl/fetch_buffer_stage.sv
// Fetch front end: PC register and instruction ROM feeding a decoupling
// queue whose head is offered to decode over valid/ready.
module fetch_buffer_stage
    import riscv_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          IMEM_WORDS = 64,
    parameter logic [63:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [31:0]              dec_instr,
    output logic [63:0]              dec_pc,
    output logic [63:0]              fetch_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(IMEM_WORDS);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ILEN-1:0] instr_mem [IMEM_WORDS];

    logic         pop;
    logic         push;
    fetch_entry_t wr_entry;
    fetch_entry_t head_entry;

    always_comb begin
        dec_valid = (occupancy != '0);
        pop       = dec_valid & dec_ready;
        push      = !redirect_valid & ((occupancy < FULL) | pop);
        wr_entry  = '{pc: fetch_pc, instr: instr_mem[fetch_pc[2 +: IDX_W]]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            fetch_pc <= RESET_PC;
        else if (redirect_valid)
            fetch_pc <= {redirect_pc[63:2], 2'b00};
        else if (push)
            fetch_pc <= fetch_pc + 64'd4;
    end

    // Redirect drives flush, which overrides any pop asserted the same cycle.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .din       (wr_entry),
        .count     (occupancy),
        .head_data (head_entry)
    );

    always_comb begin
        dec_instr = NOP_INSTR;
        dec_pc    = '0;
        if (dec_valid) begin
            dec_instr = head_entry.instr;
            dec_pc    = head_entry.pc;
        end
    end

endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Bench for fetch_buffer_stage: queue-based reference model checked every
// cycle, directed scenarios with literal pins, then randomized traffic.
module tb_fetch_buffer_stage;

    localparam int          DEPTH      = 4;
    localparam int          IMEM_WORDS = 64;
    localparam logic [63:0] RESET_PC   = 64'h0;
    localparam logic [31:0] NOP        = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic [63:0] fetch_pc;
    logic [2:0]  occupancy;

    fetch_buffer_stage #(
        .DEPTH      (DEPTH),
        .IMEM_WORDS (IMEM_WORDS),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fetch_pc       (fetch_pc),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_fpc;
    logic [31:0] mem_m [IMEM_WORDS];
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference behaviour at a rising edge, from the queue rules directly.
    task automatic model_edge();
        bit p;
        bit pu;
        if (rst) begin
            q.delete();
            m_fpc = RESET_PC;
        end else if (redirect_valid) begin
            q.delete();
            m_fpc = redirect_pc & ~64'h3;
        end else begin
            p  = (q.size() != 0) && dec_ready;
            pu = (q.size() < DEPTH) || p;
            if (p) void'(q.pop_front());
            if (pu) begin
                q.push_back('{m_fpc, mem_m[(m_fpc >> 2) % IMEM_WORDS]});
                m_fpc = m_fpc + 64'd4;
            end
        end
    endtask

    task automatic check_model();
        cmp("dec_valid", dec_valid, q.size() != 0);
        cmp("occupancy", occupancy, q.size());
        cmp("fetch_pc",  fetch_pc,  m_fpc);
        cmp("dec_pc",    dec_pc,    (q.size() != 0) ? q[0].pc : 64'h0);
        cmp("dec_instr", dec_instr, (q.size() != 0) ? q[0].instr : NOP);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;

        for (int i = 0; i < IMEM_WORDS; i++) mem_m[i] = $urandom();
        mem_m[0]  = 32'h00000033;
        mem_m[1]  = 32'h40000033;
        mem_m[2]  = 32'h0102B083;
        mem_m[3]  = 32'h00B50533;
        mem_m[4]  = 32'h00628A63;
        mem_m[5]  = 32'hFFF00293;
        mem_m[6]  = 32'h0062A023;
        mem_m[63] = 32'h0000006F;
        for (int i = 0; i < IMEM_WORDS; i++) dut.instr_mem[i] = mem_m[i];

        // Reset state
        step();
        step();
        cmp("rst_occ",   occupancy, 0);
        cmp("rst_valid", dec_valid, 0);
        cmp("rst_instr", dec_instr, 32'h00000013);
        cmp("rst_pc",    dec_pc,    0);
        cmp("rst_fpc",   fetch_pc,  0);

        // Stream
        rst       = 1'b0;
        dec_ready = 1'b1;
        step();
        cmp("first_valid", dec_valid, 1);
        cmp("first_pc",    dec_pc,    0);
        cmp("first_instr", dec_instr, 32'h00000033);
        for (int k = 2; k <= 7; k++) begin
            step();
            cmp("stream_pc", dec_pc, 64'(4 * (k - 1)));
        end
        cmp("stream_last_instr", dec_instr, 32'h0062A023);

        // Backpressure
        rst = 1'b1;
        step();
        rst       = 1'b0;
        dec_ready = 1'b0;
        repeat (8) step();
        cmp("bp_occ",   occupancy, 4);
        cmp("bp_fpc",   fetch_pc,  64'h10);
        cmp("bp_pc",    dec_pc,    0);
        cmp("bp_instr", dec_instr, 32'h00000033);
        dec_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            cmp("drain_pc", dec_pc, 64'(4 * i));
        end

        // Redirect with three entries queued
        rst = 1'b1;
        step();
        rst       = 1'b0;
        dec_ready = 1'b0;
        repeat (3) step();
        cmp("redir_pre_occ", occupancy, 3);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h13;
        step();
        cmp("redir_occ",   occupancy, 0);
        cmp("redir_valid", dec_valid, 0);
        cmp("redir_fpc",   fetch_pc,  64'h10);
        redirect_valid = 1'b0;
        step();
        cmp("redir_pc",    dec_pc,    64'h10);
        cmp("redir_instr", dec_instr, 32'h00628A63);

        // Redirect with pop while full
        repeat (5) step();
        cmp("rp_full", occupancy, 4);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h20;
        dec_ready      = 1'b1;
        step();
        cmp("rp_occ", occupancy, 0);
        redirect_valid = 1'b0;
        step();
        cmp("rp_pc", dec_pc, 64'h20);
        repeat (6) step();

        // ROM index wrap
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFC;
        step();
        redirect_valid = 1'b0;
        step();
        cmp("wrap_pc0",    dec_pc,    64'hFC);
        cmp("wrap_instr0", dec_instr, 32'h0000006F);
        step();
        cmp("wrap_pc1",    dec_pc,    64'h100);
        cmp("wrap_instr1", dec_instr, 32'h00000033);

        // Reset mid-operation with redirect pending
        dec_ready = 1'b0;
        repeat (5) step();
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        step();
        cmp("mid_occ",   occupancy, 0);
        cmp("mid_fpc",   fetch_pc,  RESET_PC);
        cmp("mid_valid", dec_valid, 0);
        cmp("mid_instr", dec_instr, 32'h00000013);
        rst            = 1'b0;
        redirect_valid = 1'b0;

        // Randomized traffic, including redirects near the top of the address space
        repeat (500) begin
            rst            = ($urandom_range(0, 59) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            else
                redirect_pc = {$urandom(), $urandom()};
            dec_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
